// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the hazard/forwarding scoreboard.
//   REG_W       : architectural register index width
//   FWD_IDEX    : EX operand select meaning "use the ID/EX latched value"
//   sb_entry_t  : one in-flight instruction record {valid, rd, load}
//   SB_BUBBLE   : empty scoreboard entry
// Legal ranges: DEPTH 2..8, LOAD_READY 2..DEPTH, FLUSH_DEPTH 0..DEPTH-1.
package hazard_scoreboard_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned FWD_IDEX = 0;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             load;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Pipeline <-> hazard scoreboard connection.
//   master : pipeline side, drives hold/flush and the ID-stage instruction fields
//   slave  : scoreboard side, returns stall, ID bypass, EX forward selects,
//            live-writer map and stall counter
interface hazard_scoreboard_if #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 32
);
  import hazard_scoreboard_pkg::*;

  localparam int unsigned SW = $clog2(DEPTH + 1);

  logic             hold;
  logic             flush;
  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             id_wr;
  logic [REG_W-1:0] id_rd;
  logic             id_load;
  logic             stall;
  logic             id_byp_rs;
  logic             id_byp_rt;
  logic [SW-1:0]    ex_fwd_rs;
  logic [SW-1:0]    ex_fwd_rt;
  logic [DEPTH-1:0] sb_valid;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output hold, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wr, id_rd, id_load,
    input  stall, id_byp_rs, id_byp_rt, ex_fwd_rs, ex_fwd_rt, sb_valid,
           stall_cnt
  );

  modport slave (
    input  hold, flush, id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
           id_wr, id_rd, id_load,
    output stall, id_byp_rs, id_byp_rt, ex_fwd_rs, ex_fwd_rt, sb_valid,
           stall_cnt
  );

endinterface

// File: rtl/hazard_scoreboard_sb_match.sv
// Priority match of one source register against all scoreboard entries.
//   entries : s[1..DEPTH] stored at index 0..DEPTH-1 (index 0 = youngest, EX)
//   src     : source register, use_src : source is actually read
//   hit_c   : some live entry writes src (src != 0)
//   idx_c   : stage number k (1..DEPTH) of the youngest matching entry
//   load_c  : that entry is a load
module hazard_scoreboard_sb_match
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned SW    = $clog2(DEPTH + 1)
) (
  input  sb_entry_t        entries [DEPTH],
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  output logic             hit_c,
  output logic [SW-1:0]    idx_c,
  output logic             load_c
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit_c  = 1'b0;
    idx_c  = '0;
    load_c = 1'b0;
    if (use_src && (src != '0)) begin
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
        if (entries[i].valid && (entries[i].rd == src)) begin
          hit_c  = 1'b1;
          idx_c  = SW'(i + 1);
          load_c = entries[i].load;
        end
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller beside the ID stage.
//   clk, rst : clock, synchronous active-high reset
//   sb       : slave side of hazard_scoreboard_if
//     inputs  hold, flush, id_valid, id_rs/rt, id_use_rs/rt, id_wr, id_rd, id_load
//     outputs stall, id_byp_rs/rt (combinational), ex_fwd_rs/rt (registered),
//             sb_valid (entry valid bits), stall_cnt (saturating)
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH       = 3,
  parameter int unsigned LOAD_READY  = 3,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned CNT_W       = 32
) (
  input logic                clk,
  input logic                rst,
  hazard_scoreboard_if.slave sb
);

  localparam int unsigned SW = $clog2(DEPTH + 1);

  sb_entry_t        ent_q [DEPTH];
  sb_entry_t        ent_d [DEPTH];
  sb_entry_t        new_ent;
  logic [SW-1:0]    fwd_rs_q, fwd_rt_q;
  logic [CNT_W-1:0] cnt_q;

  logic             hit_rs, hit_rt, ld_rs, ld_rt;
  logic [SW-1:0]    idx_rs, idx_rt;
  logic             haz_rs, haz_rt;
  logic             stall_c, issue_c;
  logic [SW-1:0]    sel_rs, sel_rt;
  logic [DEPTH-1:0] sbv;

  hazard_scoreboard_sb_match #(.DEPTH(DEPTH), .SW(SW)) u_match_rs (
    .entries (ent_q),
    .src     (sb.id_rs),
    .use_src (sb.id_use_rs),
    .hit_c   (hit_rs),
    .idx_c   (idx_rs),
    .load_c  (ld_rs)
  );

  hazard_scoreboard_sb_match #(.DEPTH(DEPTH), .SW(SW)) u_match_rt (
    .entries (ent_q),
    .src     (sb.id_rt),
    .use_src (sb.id_use_rt),
    .hit_c   (hit_rt),
    .idx_c   (idx_rt),
    .load_c  (ld_rt)
  );

  // Load data first appears at the input register of stage LOAD_READY, so a
  // load at stage k is consumable next cycle only once k+1 >= LOAD_READY.
  assign haz_rs  = hit_rs && ld_rs && (idx_rs < SW'(LOAD_READY - 1));
  assign haz_rt  = hit_rt && ld_rt && (idx_rt < SW'(LOAD_READY - 1));
  assign stall_c = sb.id_valid && (haz_rs || haz_rt) && !sb.flush;
  assign issue_c = sb.id_valid && !stall_c && !sb.flush && !sb.hold;

  // The oldest entry's result is only visible as the WB write data.
  assign sel_rs = (hit_rs && (idx_rs < SW'(DEPTH))) ? idx_rs + SW'(1) : SW'(FWD_IDEX);
  assign sel_rt = (hit_rt && (idx_rt < SW'(DEPTH))) ? idx_rt + SW'(1) : SW'(FWD_IDEX);

  // Next scoreboard contents: shift by one, then kill flushed positions.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) ent_d[i] = SB_BUBBLE;
    new_ent = SB_BUBBLE;
    if (issue_c) begin
      new_ent.valid = sb.id_wr && (sb.id_rd != '0);
      new_ent.rd    = sb.id_rd;
      new_ent.load  = sb.id_load;
    end
    ent_d[0] = new_ent;
    for (int i = 1; i < int'(DEPTH); i++) ent_d[i] = ent_q[i-1];
    if (sb.flush) begin
      for (int i = 0; i <= int'(FLUSH_DEPTH); i++) ent_d[i] = SB_BUBBLE;
    end
  end

  // State update; hold freezes everything, reset wins over hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= SB_BUBBLE;
      fwd_rs_q <= '0;
      fwd_rt_q <= '0;
      cnt_q    <= '0;
    end else if (!sb.hold) begin
      for (int i = 0; i < int'(DEPTH); i++) ent_q[i] <= ent_d[i];
      fwd_rs_q <= issue_c ? sel_rs : '0;
      fwd_rt_q <= issue_c ? sel_rt : '0;
      if (stall_c && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    sbv = '0;
    for (int i = 0; i < int'(DEPTH); i++) sbv[i] = ent_q[i].valid;
  end

  assign sb.stall     = stall_c;
  assign sb.id_byp_rs = hit_rs && (idx_rs == SW'(DEPTH));
  assign sb.id_byp_rt = hit_rt && (idx_rt == SW'(DEPTH));
  assign sb.ex_fwd_rs = fwd_rs_q;
  assign sb.ex_fwd_rt = fwd_rt_q;
  assign sb.sb_valid  = sbv;
  assign sb.stall_cnt = cnt_q;

endmodule
